// File: rtl/gb_bus_pkg.sv
// gb_bus_pkg: shared Game Boy bus constants, DMA state encoding and the echo-RAM source remap.
package gb_bus_pkg;
  localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
  localparam logic [7:0]  OAM_BASE_HI    = 8'hFE;
  localparam logic [15:0] HIGH_PAGE_BASE = 16'hFF00;
  localparam logic [7:0]  OPEN_BUS       = 8'hFF;
  typedef enum logic [1:0] {IDLE, START, XFER} dma_state_t;
  function automatic logic [7:0] echo_remap(input logic [7:0] hi);
    return (hi >= 8'hE0) ? hi - 8'h20 : hi;
  endfunction
endpackage

// File: rtl/oam_dma_controller_if.sv
// oam_dma_controller_if: CPU-side and memory-map-side bus signals around the OAM DMA controller.
interface oam_dma_controller_if;
  logic [15:0] i_CPU_Address;
  logic        i_CPU_Read;
  logic        i_CPU_Write;
  logic [7:0]  i_CPU_Data;
  logic [7:0]  o_CPU_Data;
  logic [7:0]  i_Mem_Data;
  logic [15:0] o_Mem_Address;
  logic        o_Mem_Read;
  logic        o_Mem_Write;
  logic [7:0]  o_Mem_Data;
  logic        o_DMA_Active;
  logic        o_CPU_Blocked;
  modport slave (
    input  i_CPU_Address, i_CPU_Read, i_CPU_Write, i_CPU_Data, i_Mem_Data,
    output o_CPU_Data, o_Mem_Address, o_Mem_Read, o_Mem_Write, o_Mem_Data, o_DMA_Active, o_CPU_Blocked
  );
  modport master (
    output i_CPU_Address, i_CPU_Read, i_CPU_Write, i_CPU_Data, i_Mem_Data,
    input  o_CPU_Data, o_Mem_Address, o_Mem_Read, o_Mem_Write, o_Mem_Data, o_DMA_Active, o_CPU_Blocked
  );
endinterface

// File: rtl/dma_mcycle_timer.sv
// dma_mcycle_timer: T-cycle phase and byte index counters for the OAM DMA, with stall and end-of-copy flag.
module dma_mcycle_timer #(
  parameter int DMA_LENGTH = 160
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Enable,
  input  logic       i_Clear,
  input  logic       i_Run,
  input  logic       i_Stall,
  output logic [1:0] o_Phase,
  output logic [7:0] o_Index,
  output logic       o_Mcycle_End,
  output logic       o_Last
);
  logic [1:0] r_phase;
  logic [7:0] r_index;
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_phase <= '0;
      r_index <= '0;
    end else if (i_Enable) begin
      if (i_Clear) begin
        r_phase <= '0;
        r_index <= '0;
      end else if (i_Run && !i_Stall) begin
        r_phase <= r_phase + 2'd1;
        if (r_phase == 2'd3) r_index <= r_index + 8'd1;
      end
    end
  end
  assign o_Phase      = r_phase;
  assign o_Index      = r_index;
  assign o_Mcycle_End = i_Run & ~i_Stall & (r_phase == 2'd3);
  assign o_Last       = o_Mcycle_End & (r_index == 8'(DMA_LENGTH - 1));
endmodule

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: Game Boy OAM DMA sequencer and CPU/DMA bus arbiter.
// Define OAM_DMA_ECHO_REMAP_EN to fold echo-RAM source pages (E0-FF) down to WRAM.
module oam_dma_controller
  import gb_bus_pkg::*;
#(
  parameter int DMA_LENGTH    = 160,
  parameter int START_DELAY_M = 1
) (
  input logic                  i_Clk,
  input logic                  i_Rst,
  input logic                  i_Enable,
  oam_dma_controller_if.slave  bus
);
  dma_state_t r_state;
  logic [7:0] r_src_hi, r_latch, w_src_hi, w_index;
  logic [1:0] w_phase;
  logic       w_mcycle_end, w_last, w_cpu_acc, w_reg_hit, w_trig, w_high;
  logic       w_xfer, w_stall, w_dma_bus, w_start_done, w_blocked;
`ifdef OAM_DMA_ECHO_REMAP_EN
  assign w_src_hi = echo_remap(r_src_hi);
`else
  assign w_src_hi = r_src_hi;
`endif
  assign w_cpu_acc    = bus.i_CPU_Read | bus.i_CPU_Write;
  assign w_reg_hit    = bus.i_CPU_Address == DMA_REG_ADDR;
  assign w_trig       = bus.i_CPU_Write & w_reg_hit;
  assign w_high       = bus.i_CPU_Address >= HIGH_PAGE_BASE;
  assign w_xfer       = r_state == XFER;
  // The DMA register lives here, so a trigger write never needs the external bus and never stalls the copy
  assign w_stall      = w_xfer & w_cpu_acc & w_high & ~w_trig;
  assign w_dma_bus    = w_xfer & ~w_stall;
  assign w_blocked    = w_xfer & w_cpu_acc & ~w_high;
  assign w_start_done = (r_state == START) & w_mcycle_end & (w_index == 8'(START_DELAY_M - 1));
  dma_mcycle_timer #(.DMA_LENGTH(DMA_LENGTH)) u_timer (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_Enable     (i_Enable),
    .i_Clear      (w_trig | w_start_done),
    .i_Run        (r_state != IDLE),
    .i_Stall      (w_stall),
    .o_Phase      (w_phase),
    .o_Index      (w_index),
    .o_Mcycle_End (w_mcycle_end),
    .o_Last       (w_last)
  );
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state  <= IDLE;
      r_src_hi <= '0;
      r_latch  <= '0;
    end else if (i_Enable) begin
      if (w_trig) begin
        r_state  <= START;
        r_src_hi <= bus.i_CPU_Data;
      end else if (w_start_done) r_state <= XFER;
      else if (w_xfer && w_last) r_state <= IDLE;
      if (w_dma_bus && w_phase == 2'd1) r_latch <= bus.i_Mem_Data;
    end
  end
  assign bus.o_Mem_Address = i_Rst ? '0 : w_dma_bus ? {w_phase[1] ? OAM_BASE_HI : w_src_hi, w_index} : bus.i_CPU_Address;
  assign bus.o_Mem_Read    = ~i_Rst & (w_dma_bus ? ~w_phase[1] : bus.i_CPU_Read);
  assign bus.o_Mem_Write   = ~i_Rst & (w_dma_bus ? (w_phase == 2'd3) : bus.i_CPU_Write);
  assign bus.o_Mem_Data    = w_dma_bus ? r_latch : bus.i_CPU_Data;
  assign bus.o_DMA_Active  = w_xfer;
  assign bus.o_CPU_Blocked = w_blocked;
  assign bus.o_CPU_Data    = i_Rst ? OPEN_BUS : (bus.i_CPU_Read & w_reg_hit) ? r_src_hi : w_blocked ? OPEN_BUS : bus.i_Mem_Data;
endmodule

// File: tb/tb_oam_dma_controller.sv
// tb_oam_dma_controller: directed bench with a patterned memory model and an OAM write recorder.
module tb_oam_dma_controller;
  logic i_Clk = 1'b0, i_Rst = 1'b1, i_Enable = 1'b1, clr = 1'b0;
  int n_checks = 0, n_fail = 0, wr_cnt = 0, edge_cnt = 0, last_wr = 0, trig_e = 0;
  logic [7:0] oam [160];
`ifdef OAM_DMA_ECHO_REMAP_EN
  logic [7:0] echo_hi = 8'hC2;
`else
  logic [7:0] echo_hi = 8'hE2;
`endif
  oam_dma_controller_if bus();
  oam_dma_controller dut (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enable(i_Enable), .bus(bus));
  always #5 i_Clk = ~i_Clk;
  function automatic logic [7:0] src_f(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h5A;
  endfunction
  assign bus.i_Mem_Data = src_f(bus.o_Mem_Address);
  always @(posedge i_Clk) begin
    if (!i_Rst && i_Enable) edge_cnt <= edge_cnt + 1;
    if (clr) begin
      wr_cnt <= 0;
      for (int i = 0; i < 160; i++) oam[i] <= 8'hEE;
    end else if (!i_Rst && i_Enable && bus.o_Mem_Write && bus.o_Mem_Address[15:8] == 8'hFE && bus.o_Mem_Address[7:0] < 8'd160) begin
      oam[bus.o_Mem_Address[7:0]] <= bus.o_Mem_Data;
      wr_cnt <= wr_cnt + 1;
      last_wr <= edge_cnt + 1;
    end
  end
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge i_Clk);
    #2;
  endtask
  task automatic cpu(input logic [15:0] a, input logic rd, input logic wr, input logic [7:0] d);
    bus.i_CPU_Address = a;
    bus.i_CPU_Read = rd;
    bus.i_CPU_Write = wr;
    bus.i_CPU_Data = d;
    #1;
  endtask
  task automatic trigger(input logic [7:0] d);
    cpu(16'hFF46, 1'b0, 1'b1, d);
    step();
    trig_e = edge_cnt;
    cpu(16'h0000, 1'b0, 1'b0, 8'h00);
  endtask
  task automatic clear_rec();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask
  task automatic run_until_wr(input string tag, input int n);
    for (int k = 0; k < 2000 && wr_cnt < n; k++) step();
    chk(tag, 16'(wr_cnt), 16'(n));
  endtask
  task automatic wait_idle(input string tag);
    for (int k = 0; k < 2000 && bus.o_DMA_Active; k++) step();
    chk(tag, {15'd0, bus.o_DMA_Active}, 16'd0);
  endtask
  function automatic int oam_bad(input logic [7:0] s);
    int b = 0;
    for (int i = 0; i < 160; i++) if (oam[i] !== src_f({s, 8'(i)})) b++;
    return b;
  endfunction
  initial begin
    cpu(16'h1234, 1'b1, 1'b1, 8'hAA);
    chk("rst_addr", bus.o_Mem_Address, 16'h0000);
    chk("rst_rd", {15'd0, bus.o_Mem_Read}, 16'd0);
    chk("rst_wr", {15'd0, bus.o_Mem_Write}, 16'd0);
    chk("rst_cpu_data", {8'd0, bus.o_CPU_Data}, 16'h00FF);
    chk("rst_active", {15'd0, bus.o_DMA_Active}, 16'd0);
    chk("rst_blocked", {15'd0, bus.o_CPU_Blocked}, 16'd0);
    cpu(16'h0000, 1'b0, 1'b0, 8'h00);
    step();
    i_Rst = 1'b0;
    cpu(16'hFF46, 1'b1, 1'b0, 8'h00);
    chk("reg_rst_val", {8'd0, bus.o_CPU_Data}, 16'h0000);
    cpu(16'hC234, 1'b1, 1'b0, 8'h00);
    chk("idle_pass_addr", bus.o_Mem_Address, 16'hC234);
    chk("idle_pass_data", {8'd0, bus.o_CPU_Data}, {8'd0, src_f(16'hC234)});
    cpu(16'h0000, 1'b0, 1'b0, 8'h00);
    // basic copy from C1xx
    clear_rec();
    trigger(8'hC1);
    chk("start_inactive", {15'd0, bus.o_DMA_Active}, 16'd0);
    repeat (4) step();
    chk("a_active", {15'd0, bus.o_DMA_Active}, 16'd1);
    chk("a_ph0_addr", bus.o_Mem_Address, 16'hC100);
    chk("a_ph0_rd", {15'd0, bus.o_Mem_Read}, 16'd1);
    step();
    chk("a_ph1_addr", bus.o_Mem_Address, 16'hC100);
    step();
    chk("a_ph2_addr", bus.o_Mem_Address, 16'hFE00);
    chk("a_ph2_wr", {15'd0, bus.o_Mem_Write}, 16'd0);
    step();
    chk("a_ph3_wr", {15'd0, bus.o_Mem_Write}, 16'd1);
    chk("a_ph3_data", {8'd0, bus.o_Mem_Data}, {8'd0, src_f(16'hC100)});
    wait_idle("a_idle");
    chk("a_wr_cnt", 16'(wr_cnt), 16'd160);
    chk("a_last_edge", 16'(last_wr - trig_e), 16'd644);
    chk("a_oam", 16'(oam_bad(8'hC1)), 16'd0);
    cpu(16'hFF46, 1'b1, 1'b0, 8'h00);
    chk("reg_read", {8'd0, bus.o_CPU_Data}, 16'h00C1);
    cpu(16'h0000, 1'b0, 1'b0, 8'h00);
    // blocking, pass-through stall and clock-enable hold
    clear_rec();
    trigger(8'hC3);
    run_until_wr("b_wait10", 10);
    cpu(16'h8000, 1'b1, 1'b0, 8'h00);
    chk("b_blocked", {15'd0, bus.o_CPU_Blocked}, 16'd1);
    chk("b_open_bus", {8'd0, bus.o_CPU_Data}, 16'h00FF);
    chk("b_dma_keeps_bus", bus.o_Mem_Address, 16'hC30A);
    step();
    cpu(16'hFF80, 1'b0, 1'b1, 8'h55);
    chk("b_pass_addr", bus.o_Mem_Address, 16'hFF80);
    chk("b_pass_wr", {15'd0, bus.o_Mem_Write}, 16'd1);
    chk("b_pass_data", {8'd0, bus.o_Mem_Data}, 16'h0055);
    chk("b_pass_unblocked", {15'd0, bus.o_CPU_Blocked}, 16'd0);
    step();
    cpu(16'h0000, 1'b0, 1'b0, 8'h00);
    chk("b_stall_held", bus.o_Mem_Address, 16'hC30A);
    step();
    chk("b_ph2_addr", bus.o_Mem_Address, 16'hFE0A);
    i_Enable = 1'b0;
    repeat (10) step();
    chk("b_en_hold_addr", bus.o_Mem_Address, 16'hFE0A);
    chk("b_en_hold_wr", {15'd0, bus.o_Mem_Write}, 16'd0);
    i_Enable = 1'b1;
    wait_idle("b_idle");
    chk("b_wr_cnt", 16'(wr_cnt), 16'd160);
    chk("b_last_edge", 16'(last_wr - trig_e), 16'd645);
    chk("b_oam", 16'(oam_bad(8'hC3)), 16'd0);
    // retrigger mid-copy
    clear_rec();
    trigger(8'hC5);
    run_until_wr("c_wait50", 50);
    chk("c_at50", bus.o_Mem_Address, 16'hC532);
    trigger(8'hD0);
    chk("c_restart", {15'd0, bus.o_DMA_Active}, 16'd0);
    repeat (4) step();
    chk("c_new_src", bus.o_Mem_Address, 16'hD000);
    repeat (2) step();
    chk("c_new_dst", bus.o_Mem_Address, 16'hFE00);
    wait_idle("c_idle");
    chk("c_wr_cnt", 16'(wr_cnt), 16'd210);
    chk("c_oam", 16'(oam_bad(8'hD0)), 16'd0);
    // reset mid-copy
    clear_rec();
    trigger(8'hC7);
    run_until_wr("d_wait80", 80);
    repeat (2) step();
    chk("d_ph2_addr", bus.o_Mem_Address, 16'hFE50);
    i_Rst = 1'b1;
    #1;
    chk("d_rst_rd", {15'd0, bus.o_Mem_Read}, 16'd0);
    chk("d_rst_wr", {15'd0, bus.o_Mem_Write}, 16'd0);
    chk("d_rst_active", {15'd0, bus.o_DMA_Active}, 16'd0);
    step();
    i_Rst = 1'b0;
    repeat (8) step();
    chk("d_no_more_wr", 16'(wr_cnt), 16'd80);
    chk("d_idle", {15'd0, bus.o_DMA_Active}, 16'd0);
    // echo source and trigger on the final write
    clear_rec();
    trigger(8'hE2);
    repeat (4) step();
    chk("e_src_addr", bus.o_Mem_Address, {echo_hi, 8'h00});
    cpu(16'hFF46, 1'b1, 1'b0, 8'h00);
    chk("e_reg_read", {8'd0, bus.o_CPU_Data}, 16'h00E2);
    cpu(16'h0000, 1'b0, 1'b0, 8'h00);
    run_until_wr("e_wait159", 159);
    repeat (3) step();
    cpu(16'hFF46, 1'b0, 1'b1, 8'hC9);
    chk("e_final_addr", bus.o_Mem_Address, 16'hFE9F);
    chk("e_final_wr", {15'd0, bus.o_Mem_Write}, 16'd1);
    chk("e_final_data", {8'd0, bus.o_Mem_Data}, {8'd0, src_f({echo_hi, 8'h9F})});
    step();
    cpu(16'h0000, 1'b0, 1'b0, 8'h00);
    chk("e_wr_cnt", 16'(wr_cnt), 16'd160);
    chk("e_trig_start", {15'd0, bus.o_DMA_Active}, 16'd0);
    chk("e_oam", 16'(oam_bad(echo_hi)), 16'd0);
    repeat (4) step();
    chk("e_next_src", bus.o_Mem_Address, 16'hC900);
    wait_idle("e_idle");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
Sequences the Game Boy OAM DMA transfer and arbitrates the single external memory bus between the CPU and the DMA engine. A CPU write to 0xFF46 with value XX copies 160 bytes from XX00–XX9F to FE00–FE9F, one byte per M-cycle. While the copy runs, CPU accesses below 0xFF00 are masked. The block sits between the CPU bus interface (ControlUnit-driven address/data lines) and the memory map decoder.

Parameters:
DMA_LENGTH, 160, bytes per transfer (index width 8 bits)
START_DELAY_M, 1, M-cycles between the trigger write and the first transfer M-cycle

Ports:
i_Clk  input  1  system clock
i_Rst  input  1  asynchronous reset, active-high
i_Enable  input  1  T-cycle clock enable; all state holds when low
i_CPU_Address  input  16  CPU bus address
i_CPU_Read  input  1  CPU read strobe
i_CPU_Write  input  1  CPU write strobe
i_CPU_Data  input  8  CPU write data
o_CPU_Data  output  8  read data returned to the CPU
i_Mem_Data  input  8  read data from memory map
o_Mem_Address  output  16  address to memory map
o_Mem_Read  output  1  memory read strobe
o_Mem_Write  output  1  memory write strobe
o_Mem_Data  output  8  write data to memory map
o_DMA_Active  output  1  high in XFER state (bus owned by DMA)
o_CPU_Blocked  output  1  high when the current CPU access is masked

Behaviour:
- Reset (async, i_Rst=1): state=IDLE, phase=0, index=0, src_hi=0x00, latch=0x00. All o_Mem_* strobes are 0, o_Mem_Address=0, o_DMA_Active=0, o_CPU_Blocked=0, o_CPU_Data=0xFF. Reset mid-transfer aborts with no further writes.
- States: IDLE -> START -> XFER -> IDLE.
- Trigger: on an enabled clock with i_CPU_Write=1 and i_CPU_Address=0xFF46:
  - src_hi <= i_CPU_Data, index <= 0, phase <= 0, state <= START.
  - This is legal from any state. A retrigger during XFER aborts the current copy and restarts.
- phase: 2-bit counter advancing on each enabled clock in START/XFER. Wraps 3->0 at each M-cycle boundary.
- START: lasts START_DELAY_M×4 enabled clocks. The CPU keeps the bus. Then XFER.
- XFER, per M-cycle:
  - phase 0–1: o_Mem_Address={src_hi,index}, o_Mem_Read=1. latch <= i_Mem_Data at the enabled clock of phase 1.
  - phase 2–3: o_Mem_Address={8'hFE,index}, o_Mem_Write=1 in phase 3 only, o_Mem_Data=latch.
  - At the phase 3 clock, index increments. At phase 3 with index=DMA_LENGTH-1, go to IDLE.
- Total copy time: 4×(START_DELAY_M+160) enabled clocks after the trigger clock.
- Arbitration in XFER:
  - A CPU access with address ≥0xFF00 is passed through (HRAM/IO). It takes the bus combinationally that cycle, and the DMA slot is stalled (phase holds).
  - Any other CPU access is blocked: o_CPU_Blocked=1, writes are dropped, reads return 0xFF.
- Outside XFER: o_Mem_* mirror the CPU signals combinationally; o_CPU_Data=i_Mem_Data.
- Register read: a CPU read of 0xFF46 returns src_hi in any state.
- Simultaneous events:
  - A trigger on the same clock as the final phase-3 write: the write completes, then the trigger wins (START).
  - A trigger in START restarts the delay with the new src_hi.
- i_Enable=0: no state change. Outputs are held and combinational pass-through remains valid.

Optional Feature:
OAM_DMA_ECHO_REMAP_EN
- Defined: a source high byte 0xE0–0xFF is remapped to src_hi−0x20 (echo RAM to WRAM). The stored register value is unchanged on readback.
- Undefined: the source high byte is used verbatim.

Decomposition:
- Shared package gb_bus_pkg:
  - constants DMA_REG_ADDR=16'hFF46, OAM_BASE_HI=8'hFE, HIGH_PAGE_BASE=16'hFF00, OPEN_BUS=8'hFF
  - DMA state enum (IDLE, START, XFER)
- One sub-module: dma_mcycle_timer, holding the phase counter, index counter, stall input and end-of-transfer flag.

Test Plan:
- Reset, then write 0xC1 to FF46. After 4 clocks of START: read C100 in phases 0–1, write FE00 in phase 3. Last write FE9F at enabled clock 4+640. Then IDLE.
- During XFER, CPU read of 0x8000 -> o_CPU_Blocked=1 and data 0xFF. CPU write 0x55 to 0xFF80 -> passes through and the DMA phase stalls one clock. OAM contents remain correct.
- Retrigger with 0xD0 at index 50 -> next write goes to FE00 with source D000. FE32 onward is not written from the old source.
- Assert i_Rst at index 80 in phase 2 -> strobes low immediately, no write at phase 3. State is IDLE after release.
- Hold i_Enable low for 10 clocks mid-XFER -> no address/phase change. The transfer resumes and completes with 160 writes total.
- With OAM_DMA_ECHO_REMAP_EN defined, write 0xE2 -> reads from C200–C29F. A read of FF46 returns 0xE2.
